// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the instruction encoder: request formats,
// RV32I opcodes, immediate ranges and the controller states.
package inst_enc_pkg;

    typedef enum logic [2:0] {
        I_ARITH = 3'd0,
        I_SHIFT = 3'd1,
        LOAD    = 3'd2,
        STORE   = 3'd3,
        BRANCH  = 3'd4,
        LUI     = 3'd5
    } fmt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        WRITE  = 2'd2,
        FULL   = 2'd3
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;

endpackage

// File: rtl/inst_pack.sv
// Purely combinational packer: turns decoded fields plus a full 32-bit
// immediate into an RV32I word and reports whether the immediate fits.
module inst_pack
    import inst_enc_pkg::*;
(
    input  fmt_t        format_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    logic immIFits;
    logic immBFits;
    logic shiftOk;

    assign immIFits = ($signed(imm_i) >= IMM_I_MIN) && ($signed(imm_i) <= IMM_I_MAX);
    assign immBFits = ($signed(imm_i) >= IMM_B_MIN) && ($signed(imm_i) <= IMM_B_MAX)
                      && (imm_i[0] == 1'b0);

    // SRAI is the only shift that may carry the 0100000 funct7 variant.
    assign shiftOk = (imm_i[31:5] == 27'd0)
                     && ((funct3_i == 3'b001) || (funct3_i == 3'b101))
                     && ((funct7_i == 7'b0000000)
                         || ((funct7_i == 7'b0100000) && (funct3_i == 3'b101)));

    always_comb begin
        word_o  = '0;
        legal_o = 1'b0;
        case (format_i)
            I_ARITH: begin
                word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_IMM};
                legal_o = immIFits;
            end
            I_SHIFT: begin
                word_o  = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_IMM};
                legal_o = shiftOk;
            end
            LOAD: begin
                word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
                legal_o = immIFits;
            end
            STORE: begin
                word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
                legal_o = immIFits;
            end
            BRANCH: begin
                word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], OP_BRANCH};
                legal_o = immBFits;
            end
            LUI: begin
                word_o  = {imm_i[31:12], rd_i, OP_LUI};
                legal_o = (imm_i[11:0] == 12'd0);
            end
            default: begin
                word_o  = '0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Accepts decoded instruction requests, encodes them through inst_pack and
// writes legal words sequentially into instruction memory via a stallable port.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH     = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Clear,
    input  logic                         InValid,
    output logic                         InReady,
    input  fmt_t                         Format,
    input  logic [2:0]                   Funct3,
    input  logic [6:0]                   Funct7,
    input  logic [4:0]                   Rd,
    input  logic [4:0]                   Rs1,
    input  logic [4:0]                   Rs2,
    input  logic [31:0]                  Imm,
    output logic                         MemWrEn,
    output logic [ADDR_W-1:0]            MemAddr,
    output logic [31:0]                  MemWrData,
    input  logic                         MemReady,
    output logic                         ErrPulse,
    output logic                         ErrSticky,
    output logic [7:0]                   ErrCount,
    output logic [$clog2(DEPTH+1)-1:0]   WordCount,
    output logic                         Full
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_t              state_q;
    logic                inReady_q;
    logic                memWrEn_q;
    logic [ADDR_W-1:0]   memAddr_q;
    logic [31:0]         memWrData_q;
    logic                errPulse_q;
    logic                errSticky_q;
    logic [7:0]          errCount_q;
    logic [CNT_W-1:0]    wordCount_q;
    logic                full_q;

    fmt_t                format_q;
    logic [2:0]          funct3_q;
    logic [6:0]          funct7_q;
    logic [4:0]          rd_q;
    logic [4:0]          rs1_q;
    logic [4:0]          rs2_q;
    logic [31:0]         imm_q;

    logic [31:0]         packWord_d;
    logic                packLegal_d;
    logic [CNT_W-1:0]    wordCount_d;

    inst_pack u_pack (
        .format_i (format_q),
        .funct3_i (funct3_q),
        .funct7_i (funct7_q),
        .rd_i     (rd_q),
        .rs1_i    (rs1_q),
        .rs2_i    (rs2_q),
        .imm_i    (imm_q),
        .word_o   (packWord_d),
        .legal_o  (packLegal_d)
    );

    assign wordCount_d = wordCount_q + CNT_W'(1);

    // Clear behaves exactly like reset, so one branch covers both and an
    // in-flight write is simply abandoned.
    always_ff @(posedge clk) begin
        if (reset || Clear) begin
            state_q     <= IDLE;
            inReady_q   <= 1'b1;
            memWrEn_q   <= 1'b0;
            memAddr_q   <= BASE_ADDR;
            memWrData_q <= '0;
            errPulse_q  <= 1'b0;
            errSticky_q <= 1'b0;
            errCount_q  <= '0;
            wordCount_q <= '0;
            full_q      <= 1'b0;
            format_q    <= I_ARITH;
            funct3_q    <= '0;
            funct7_q    <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
        end else begin
            errPulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (InValid && inReady_q) begin
                        format_q  <= Format;
                        funct3_q  <= Funct3;
                        funct7_q  <= Funct7;
                        rd_q      <= Rd;
                        rs1_q     <= Rs1;
                        rs2_q     <= Rs2;
                        imm_q     <= Imm;
                        inReady_q <= 1'b0;
                        state_q   <= ENCODE;
                    end
                end
                ENCODE: begin
                    memWrData_q <= packWord_d;
                    if (packLegal_d) begin
                        memWrEn_q <= 1'b1;
                        state_q   <= WRITE;
                    end else begin
                        errPulse_q  <= 1'b1;
                        errSticky_q <= 1'b1;
                        if (errCount_q != 8'hFF) begin
                            errCount_q <= errCount_q + 8'd1;
                        end
                        inReady_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                WRITE: begin
                    if (MemReady) begin
                        memWrEn_q   <= 1'b0;
                        memAddr_q   <= memAddr_q + ADDR_W'(4);
                        wordCount_q <= wordCount_d;
                        if (wordCount_d == CNT_W'(DEPTH)) begin
                            full_q  <= 1'b1;
                            state_q <= FULL;
                        end else begin
                            inReady_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                FULL: begin
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign InReady   = inReady_q;
    assign MemWrEn   = memWrEn_q;
    assign MemAddr   = memAddr_q;
    assign MemWrData = memWrData_q;
    assign ErrPulse  = errPulse_q;
    assign ErrSticky = errSticky_q;
    assign ErrCount  = errCount_q;
    assign WordCount = wordCount_q;
    assign Full      = full_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: a 64-deep instance for packing, errors,
// stalls and reset, plus a 4-deep instance sharing the inputs for the Full case.
module tb_inst_encoder;
    import inst_enc_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset, Clear, InValid, MemReady;
    fmt_t        Format;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [4:0]  Rd, Rs1, Rs2;
    logic [31:0] Imm;

    logic        mInReady, mMemWrEn, mErrPulse, mErrSticky, mFull;
    logic [31:0] mMemAddr, mMemWrData;
    logic [7:0]  mErrCount;
    logic [6:0]  mWordCount;

    logic        sInReady, sMemWrEn, sErrPulse, sErrSticky, sFull;
    logic [31:0] sMemAddr, sMemWrData;
    logic [7:0]  sErrCount;
    logic [2:0]  sWordCount;

    int          compareCount = 0;
    int          failCount = 0;

    wr_t         mQ[$];
    wr_t         sQ[$];
    logic [31:0] mExpAddr = 32'd0, sExpAddr = 32'd0;
    int          mExpWc = 0, sExpWc = 0, mExpErr = 0, mPulses = 0;
    logic        curLegal = 1'b0;
    logic [31:0] curWord = 32'd0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(64)) dut (
        .clk(clk), .reset(reset), .Clear(Clear), .InValid(InValid), .InReady(mInReady),
        .Format(Format), .Funct3(Funct3), .Funct7(Funct7), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
        .Imm(Imm), .MemWrEn(mMemWrEn), .MemAddr(mMemAddr), .MemWrData(mMemWrData),
        .MemReady(MemReady), .ErrPulse(mErrPulse), .ErrSticky(mErrSticky),
        .ErrCount(mErrCount), .WordCount(mWordCount), .Full(mFull)
    );

    inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) dutSmall (
        .clk(clk), .reset(reset), .Clear(Clear), .InValid(InValid), .InReady(sInReady),
        .Format(Format), .Funct3(Funct3), .Funct7(Funct7), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
        .Imm(Imm), .MemWrEn(sMemWrEn), .MemAddr(sMemAddr), .MemWrData(sMemWrData),
        .MemReady(MemReady), .ErrPulse(sErrPulse), .ErrSticky(sErrSticky),
        .ErrCount(sErrCount), .WordCount(sWordCount), .Full(sFull)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addiWord(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm12);
        return {imm12, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    // Scoreboard: push on handshake, pop and compare on each committed write.
    always @(negedge clk) begin
        if (reset || Clear) begin
            mQ.delete(); sQ.delete();
            mExpAddr = 32'd0; sExpAddr = 32'd0;
            mExpWc = 0; sExpWc = 0; mExpErr = 0;
        end else begin
            if (InValid && mInReady) begin
                if (curLegal) begin
                    mQ.push_back('{mExpAddr, curWord});
                    mExpAddr = mExpAddr + 32'd4;
                end else if (mExpErr != 255) begin
                    mExpErr++;
                end
            end
            if (InValid && sInReady && curLegal) begin
                sQ.push_back('{sExpAddr, curWord});
                sExpAddr = sExpAddr + 32'd4;
            end
            if (mErrPulse) mPulses++;
            if (mMemWrEn && MemReady) begin
                if (mQ.size() == 0) begin
                    checkOutput("m_unexpected_write", 64'(mMemAddr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t e;
                    e = mQ.pop_front();
                    checkOutput("m_wr_addr", 64'(mMemAddr), 64'(e.addr));
                    checkOutput("m_wr_data", 64'(mMemWrData), 64'(e.data));
                    mExpWc++;
                end
            end
            if (sMemWrEn && MemReady) begin
                if (sQ.size() == 0) begin
                    checkOutput("s_unexpected_write", 64'(sMemAddr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t e;
                    e = sQ.pop_front();
                    checkOutput("s_wr_addr", 64'(sMemAddr), 64'(e.addr));
                    checkOutput("s_wr_data", 64'(sMemWrData), 64'(e.data));
                    sExpWc++;
                end
            end
        end
    end

    task automatic applyStimulus(input fmt_t fmt, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input logic legal, input logic [31:0] word,
                                 input bit useSmall);
        int n = 0;
        Format = fmt; Funct3 = f3; Funct7 = f7; Rd = rd; Rs1 = rs1; Rs2 = rs2; Imm = imm;
        curLegal = legal; curWord = word;
        InValid = 1'b1;
        forever begin
            @(negedge clk);
            if (useSmall ? sInReady : mInReady) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) checkOutput("accept_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        InValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        forever begin
            @(negedge clk);
            if (mQ.size() == 0 && sQ.size() == 0) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) checkOutput("drain_timeout", 64'(mQ.size() + sQ.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulsesBefore;
        reset = 1'b1; Clear = 1'b0; InValid = 1'b0; MemReady = 1'b1;
        Format = I_ARITH; Funct3 = '0; Funct7 = '0; Rd = '0; Rs1 = '0; Rs2 = '0; Imm = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_inready",   64'(mInReady),   64'd1);
        checkOutput("rst_wren",      64'(mMemWrEn),   64'd0);
        checkOutput("rst_addr",      64'(mMemAddr),   64'd0);
        checkOutput("rst_wrdata",    64'(mMemWrData), 64'd0);
        checkOutput("rst_errpulse",  64'(mErrPulse),  64'd0);
        checkOutput("rst_errsticky", 64'(mErrSticky), 64'd0);
        checkOutput("rst_errcount",  64'(mErrCount),  64'd0);
        checkOutput("rst_wordcount", 64'(mWordCount), 64'd0);
        checkOutput("rst_full",      64'(mFull),      64'd0);
        @(posedge clk); #1;

        $display("[TB] legal packing");
        applyStimulus(I_ARITH, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, 1'b0);
        checkOutput("lat_encode_wren", 64'(mMemWrEn), 64'd0);
        checkOutput("lat_busy_inready", 64'(mInReady), 64'd0);
        @(posedge clk); #1;
        checkOutput("lat_write_wren", 64'(mMemWrEn), 64'd1);
        applyStimulus(I_SHIFT, 3'b101, 7'b0100000, 5'd2, 5'd1, 5'd0, 32'd3, 1'b1, 32'h4030_D113, 1'b0);
        applyStimulus(STORE, 3'b010, 7'd0, 5'd0, 5'd2, 5'd5, -32'sd4, 1'b1, 32'hFE51_2E23, 1'b0);
        applyStimulus(BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 32'hFE20_8CE3, 1'b0);
        applyStimulus(LUI, 3'b000, 7'd0, 5'd3, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_51B7, 1'b0);
        waitDrain();
        checkOutput("t1_wordcount", 64'(mWordCount), 64'd5);
        checkOutput("t1_addr", 64'(mMemAddr), 64'h14);

        $display("[TB] rejections");
        pulsesBefore = mPulses;
        applyStimulus(I_ARITH, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0, 1'b0);
        applyStimulus(BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd5, 1'b0, 32'h0, 1'b0);
        applyStimulus(LUI, 3'b000, 7'd0, 5'd3, 5'd0, 5'd0, 32'h0000_0800, 1'b0, 32'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t2_pulses", 64'(mPulses - pulsesBefore), 64'd3);
        checkOutput("t2_sticky", 64'(mErrSticky), 64'd1);
        checkOutput("t2_errcount", 64'(mErrCount), 64'd3);
        checkOutput("t2_addr", 64'(mMemAddr), 64'h14);
        checkOutput("t2_wordcount", 64'(mWordCount), 64'd5);

        $display("[TB] immediate boundaries");
        applyStimulus(I_ARITH, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd2048, 1'b1, 32'h8000_0093, 1'b0);
        applyStimulus(I_ARITH, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047, 1'b1, 32'h7FF0_0093, 1'b0);
        applyStimulus(I_ARITH, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd2049, 1'b0, 32'h0, 1'b0);
        applyStimulus(BRANCH, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4094, 1'b1, 32'h7E00_0FE3, 1'b0);
        applyStimulus(BRANCH, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4096, 1'b1, 32'h8000_0063, 1'b0);
        applyStimulus(BRANCH, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096, 1'b0, 32'h0, 1'b0);
        applyStimulus(I_SHIFT, 3'b001, 7'd0, 5'd1, 5'd1, 5'd0, 32'd31, 1'b1, 32'h01F0_9093, 1'b0);
        applyStimulus(I_SHIFT, 3'b001, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd3, 1'b0, 32'h0, 1'b0);
        applyStimulus(I_SHIFT, 3'b101, 7'd0, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0, 32'h0, 1'b0);
        applyStimulus(LOAD, 3'b010, 7'd0, 5'd4, 5'd3, 5'd0, -32'sd1, 1'b1, 32'hFFF1_A203, 1'b0);
        waitDrain();
        checkOutput("t2b_wordcount", 64'(mWordCount), 64'd11);
        checkOutput("t2b_errcount", 64'(mErrCount), 64'd7);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 250; i++) begin
            applyStimulus(I_ARITH, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 32'h0, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sat_errcount", 64'(mErrCount), 64'd255);
        checkOutput("sat_model", 64'(mErrCount), 64'(mExpErr));

        $display("[TB] memory stall");
        MemReady = 1'b0;
        applyStimulus(I_ARITH, 3'b000, 7'd0, 5'd6, 5'd0, 5'd0, 32'd42, 1'b1, addiWord(5'd6, 5'd0, 12'd42), 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_wren", 64'(mMemWrEn), 64'd1);
            checkOutput("stall_addr", 64'(mMemAddr), 64'(mExpAddr - 32'd4));
            checkOutput("stall_data", 64'(mMemWrData), 64'(addiWord(5'd6, 5'd0, 12'd42)));
            checkOutput("stall_wordcount", 64'(mWordCount), 64'd11);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        MemReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall_commit_wren", 64'(mMemWrEn), 64'd0);
        checkOutput("stall_commit_wc", 64'(mWordCount), 64'd12);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_once_wc", 64'(mWordCount), 64'(mExpWc));

        $display("[TB] full on small instance");
        Clear = 1'b1;
        @(posedge clk); #1;
        Clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(I_ARITH, 3'b000, 7'd0, 5'd8, 5'd0, 5'd0, 32'(i + 10), 1'b1,
                          addiWord(5'd8, 5'd0, 12'(i + 10)), 1'b1);
        end
        waitDrain();
        checkOutput("full_flag", 64'(sFull), 64'd1);
        checkOutput("full_inready", 64'(sInReady), 64'd0);
        checkOutput("full_wordcount", 64'(sWordCount), 64'd4);
        checkOutput("full_addr", 64'(sMemAddr), 64'h10);
        Format = I_ARITH; Funct3 = 3'b000; Funct7 = 7'd0; Rd = 5'd9; Rs1 = 5'd0; Rs2 = 5'd0; Imm = 32'd99;
        curLegal = 1'b1; curWord = addiWord(5'd9, 5'd0, 12'd99);
        InValid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("full_reject_inready", 64'(sInReady), 64'd0);
        end
        @(posedge clk); #1;
        InValid = 1'b0;
        checkOutput("full_hold_wordcount", 64'(sWordCount), 64'd4);
        checkOutput("full_hold_flag", 64'(sFull), 64'd1);
        Clear = 1'b1;
        @(posedge clk); #1;
        Clear = 1'b0;
        checkOutput("clr_full", 64'(sFull), 64'd0);
        checkOutput("clr_addr", 64'(sMemAddr), 64'd0);
        checkOutput("clr_wordcount", 64'(sWordCount), 64'd0);
        checkOutput("clr_inready", 64'(sInReady), 64'd1);
        checkOutput("clr_m_sticky", 64'(mErrSticky), 64'd0);
        checkOutput("clr_m_errcount", 64'(mErrCount), 64'd0);
        checkOutput("clr_m_wren", 64'(mMemWrEn), 64'd0);

        $display("[TB] reset during write");
        MemReady = 1'b0;
        applyStimulus(I_ARITH, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'd7, 1'b1, addiWord(5'd5, 5'd0, 12'd7), 1'b0);
        @(posedge clk); #1;
        checkOutput("rw_pending_wren", 64'(mMemWrEn), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("rw_wren", 64'(mMemWrEn), 64'd0);
        checkOutput("rw_addr", 64'(mMemAddr), 64'd0);
        checkOutput("rw_wordcount", 64'(mWordCount), 64'd0);
        checkOutput("rw_inready", 64'(mInReady), 64'd1);
        checkOutput("rw_wrdata", 64'(mMemWrData), 64'd0);
        reset = 1'b0;
        MemReady = 1'b1;
        applyStimulus(I_ARITH, 3'b000, 7'd0, 5'd7, 5'd0, 5'd0, 32'd100, 1'b1, addiWord(5'd7, 5'd0, 12'd100), 1'b0);
        waitDrain();
        checkOutput("rw_after_wordcount", 64'(mWordCount), 64'd1);
        checkOutput("rw_after_addr", 64'(mMemAddr), 64'd4);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Inverse of the immediate generator. It takes decoded instruction fields (format, funct3/funct7, register indices, full 32-bit immediate) and packs them into a legal RV32I instruction word. It range-checks the immediate against the format and writes accepted words sequentially into instruction memory through a stallable write port. It serves as the bench/boot-loader path for filling instruction memory and as the golden inverse for immediate-generator verification.

Parameters:
ADDR_W, 32, width of instruction-memory byte address
BASE_ADDR, 0, byte address of the first word written
DEPTH, 64, maximum words written before Full

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
Clear  in  1  synchronous restart of address, counters and flags; priority below reset, above all else
InValid  in  1  request valid
InReady  out  1  encoder can accept a request
Format  in  3  fmt_t: I_ARITH, I_SHIFT, LOAD, STORE, BRANCH, LUI
Funct3  in  3  funct3 field (ignored for LUI)
Funct7  in  7  funct7; only I_SHIFT uses it (0000000 or 0100000)
Rd  in  5  destination register
Rs1  in  5  source register 1
Rs2  in  5  source register 2
Imm  in  32  immediate as the immediate generator outputs it (sign-extended; shift amount in [4:0]; LUI value with [11:0]=0)
MemWrEn  out  1  write request to instruction memory
MemAddr  out  ADDR_W  byte address of the write
MemWrData  out  32  encoded instruction
MemReady  in  1  memory accepts the write this cycle
ErrPulse  out  1  one-cycle pulse when a request is rejected
ErrSticky  out  1  set on any rejection; cleared by reset or Clear
ErrCount  out  8  rejected requests, saturating at 255
WordCount  out  $clog2(DEPTH+1)  words written
Full  out  1  WordCount == DEPTH

Behaviour:
- Reset: state IDLE, InReady=1, MemWrEn=0, MemAddr=BASE_ADDR, MemWrData=0, ErrPulse=0, ErrSticky=0, ErrCount=0, WordCount=0, Full=0.
- FSM states: IDLE, ENCODE, WRITE, FULL.
- IDLE: InReady=1. A handshake (InValid & InReady) latches all fields and moves to ENCODE. InReady is 0 in every other state.
- ENCODE (exactly one cycle): range-check the immediate and assemble the word into the MemWrData register.
  - Pass: go to WRITE.
  - Fail: ErrPulse=1 for this cycle, ErrSticky set, ErrCount increments, return to IDLE. No write is issued.
- Opcodes:
  - I_ARITH and I_SHIFT: 0010011
  - LOAD: 0000011
  - STORE: 0100011
  - BRANCH: 1100011
  - LUI: 0110111
- Legality checks:
  - I_ARITH, LOAD, STORE: signed Imm in [-2048, 2047].
  - I_SHIFT: Imm[31:5]==0; Funct3 in {001, 101}; Funct7 in {0000000, 0100000}; Funct7=0100000 is allowed only with Funct3=101.
  - BRANCH: Imm[0]==0 and signed Imm in [-4096, 4094].
  - LUI: Imm[11:0]==0.
- Packing follows standard RV32I I/S/B/U layouts; the I_SHIFT word is {Funct7, Imm[4:0], Rs1, Funct3, Rd, opcode}.
- WRITE:
  - MemWrEn=1, with MemAddr and MemWrData held stable until MemReady=1 is sampled.
  - On that edge: MemWrEn drops, MemAddr += 4, WordCount += 1.
  - Next state is FULL if the new WordCount == DEPTH, otherwise IDLE.
- Latency: handshake at cycle N, MemWrEn first high at N+2. Peak throughput is one word per 3 cycles with MemReady held high.
- FULL: Full=1, InReady=0. Leave only by reset or Clear.
- MemAddr wraps modulo 2^ADDR_W. This is unreachable when BASE_ADDR + 4*DEPTH fits.
- Clear, in any state: same values as reset, except it has no effect when reset is also asserted (reset wins). An in-flight write in WRITE is dropped.
- Reset mid-WRITE: MemWrEn=0 on the next cycle; nothing is committed.
- ErrCount saturates at 255 and stays there.

Decomposition:
- Package inst_enc_pkg holds:
  - fmt_t enum
  - opcode localparams (OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI)
  - IMM_I_MIN/MAX and IMM_B_MIN/MAX constants
- One combinational sub-module, inst_pack: fields + Imm in, {Word[31:0], Legal} out. Keeping it separate lets it be checked exhaustively against the immediate generator. The FSM, counters and memory port stay in inst_encoder.

Test Plan:
1. Legal packing, MemReady held 1, BASE_ADDR=0. Send each request below; MemWrData must match, MemAddr increments 0x0, 0x4, 0x8, 0xC, 0x10, and WordCount ends at 5.
   - ADDI x1,x0,5 -> 0x00500093
   - SRAI x2,x1,3 -> 0x4030D113
   - SW x5,-4(x2) -> 0xFE512E23
   - BEQ x1,x2,-8 -> 0xFE208CE3
   - LUI x3,0x12345000 -> 0x123451B7
2. Rejections -> one ErrPulse each, no MemWrEn, ErrSticky=1, ErrCount=3, MemAddr unchanged.
   - I_ARITH Imm=2048
   - BRANCH Imm=5
   - LUI Imm=0x00000800
3. Memory stall: MemReady=0 for 3 cycles during WRITE -> MemWrEn, MemAddr, MemWrData stable all 3 cycles; single commit when MemReady=1; WordCount += 1 exactly once.
4. DEPTH=4: five back-to-back legal requests -> four writes; Full=1 and InReady=0 after the fourth commit; fifth request not accepted; Clear -> Full=0, MemAddr=BASE_ADDR, WordCount=0.
5. Reset asserted in WRITE with MemReady=0 -> MemWrEn=0 next cycle, all outputs at reset values, no commit; a following ADDI is written at BASE_ADDR.
